// File: rtl/ps2_rx_fifo.sv
// ----------------------------------------------------------------------------
// ps2_rx_fifo
//   PS/2 device-to-host receiver with a byte FIFO on the read side.
//   The receiver synchronises the raw PS/2 pins and samples data on each
//   falling edge of the synchronised PS/2 clock. It decodes the 11-bit frame:
//   start, 8 data bits LSB first, odd parity, and stop. A watchdog drops a
//   frame that stalls. Each accepted byte is queued for the CPU, which reads
//   it through a valid/ready handshake. The last two accepted bytes are also
//   kept as a 16-bit history word, and sticky error flags are provided.
//
// Ports
//   clk, rst_n      system clock; asynchronous active-low reset
//   ps2_clk         raw PS/2 clock pin (asynchronous)
//   ps2_data        raw PS/2 data pin (asynchronous)
//   rd_data         FIFO head byte; reads 0 while the FIFO is empty
//   rd_valid        FIFO is non-empty
//   rd_ready        pops the head when rd_valid is also high
//   count           FIFO occupancy, 0..FIFO_DEPTH
//   last_code       {previous accepted byte, latest accepted byte}
//   err_parity      sticky flag: a frame was rejected on a parity mismatch
//   err_frame       sticky flag: bad stop bit or watchdog timeout
//   err_overflow    sticky flag: a good byte was dropped because the FIFO was full
//   err_clr         synchronous clear of the three flags; a set in the same
//                   cycle wins over the clear
// ----------------------------------------------------------------------------
module ps2_rx_fifo #(
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic [15:0]                   last_code,
   output logic                          err_parity,
   output logic                          err_frame,
   output logic                          err_overflow,
   input  logic                          err_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   // ---------------------------------------------------------------------
   // Input synchronisers and falling-edge detection
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   logic                   sample;
   logic                   data_bit;

   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
   end

   assign sample   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
   assign data_bit = data_sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // Frame decoder FSM with inter-edge watchdog
   // ---------------------------------------------------------------------
   logic [1:0]    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          frame_ok;
   logic          set_par;
   logic          set_frm;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      to_cnt_d  = '0;
      frame_ok  = 1'b0;
      set_par   = 1'b0;
      set_frm   = 1'b0;

      if (state_q != ST_IDLE) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end

      if (sample) begin
         // Each edge restarts the watchdog.
         to_cnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!data_bit) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shift_d   = {data_bit, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               par_d   = data_bit;
               state_d = ST_STOP;
            end
            default: begin
               // Stop-bit sample. Parity is odd over the byte plus the parity bit.
               state_d  = ST_IDLE;
               frame_ok = data_bit & (^{shift_q, par_q});
               set_par  = ~(^{shift_q, par_q});
               set_frm  = ~data_bit;
            end
         endcase
      end else if ((state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYC - 1))) begin
         state_d  = ST_IDLE;
         to_cnt_d = '0;
         set_frm  = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Byte FIFO
   // ---------------------------------------------------------------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full;
   logic          do_pop;
   logic          do_push;
   logic          overflow;

   assign rd_valid = (count_q != '0);
   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign do_pop   = rd_valid & rd_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
   assign do_push  = frame_ok & (~full | do_pop);
   assign overflow = frame_ok & full & ~do_pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   assign rd_data = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign count   = count_q;

   // ---------------------------------------------------------------------
   // History word and sticky error flags
   // ---------------------------------------------------------------------
   logic [15:0] last_code_q, last_code_d;
   logic        err_par_q, err_par_d;
   logic        err_frm_q, err_frm_d;
   logic        err_ovf_q, err_ovf_d;

   always_comb begin
      // The history tracks every accepted byte, including one dropped on overflow.
      last_code_d = frame_ok ? {last_code_q[7:0], shift_q} : last_code_q;
      err_par_d   = set_par  | (err_par_q & ~err_clr);
      err_frm_d   = set_frm  | (err_frm_q & ~err_clr);
      err_ovf_d   = overflow | (err_ovf_q & ~err_clr);
   end

   assign last_code    = last_code_q;
   assign err_parity   = err_par_q;
   assign err_frame    = err_frm_q;
   assign err_overflow = err_ovf_q;

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // The pins idle high; starting the chain high avoids a false edge.
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         last_code_q <= '0;
         err_par_q   <= 1'b0;
         err_frm_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         clk_prev_q  <= clk_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         to_cnt_q    <= to_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         last_code_q <= last_code_d;
         err_par_q   <= err_par_d;
         err_frm_q   <= err_frm_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx_fifo
//   Self-checking bench for ps2_rx_fifo. PS/2 frames are driven on the pins.
//   The expected FIFO contents, history word and error flags come from a
//   queue-based model of the frame rules.
// ----------------------------------------------------------------------------
module tb_ps2_rx_fifo;

   localparam int S    = 2;
   localparam int D    = 4;
   localparam int TO   = 5000;
   localparam int HALF = 6;     // clk cycles per PS/2 clock half-period

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [2:0]  count;
   logic [15:0] last_code;
   logic        err_parity, err_frame, err_overflow;
   logic        err_clr = 1'b0;

   ps2_rx_fifo #(.SYNC_STAGES(S), .FIFO_DEPTH(D), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .count(count), .last_code(last_code),
      .err_parity(err_parity), .err_frame(err_frame), .err_overflow(err_overflow),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model
   logic [7:0]  m_q[$];
   logic [15:0] m_last = 16'h0000;
   bit          m_par = 1'b0, m_frm = 1'b0, m_ovf = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".valid"}, 32'(rd_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check_val({tag, ".data"}, 32'(rd_data), 32'(m_q[0]));
      check_val({tag, ".count"}, 32'(count), 32'(m_q.size()));
      check_val({tag, ".last"}, 32'(last_code), 32'(m_last));
      check_val({tag, ".epar"}, 32'(err_parity), 32'(m_par));
      check_val({tag, ".efrm"}, 32'(err_frame), 32'(m_frm));
      check_val({tag, ".eovf"}, 32'(err_overflow), 32'(m_ovf));
   endtask

   // Drives one bit: data changes while the PS/2 clock is high, then the clock
   // falls. strobe[0] pulses rd_ready and strobe[1] pulses err_clr for one
   // clk cycle on the clk edge that registers this bit's sample.
   task automatic send_bit(input logic b, input logic [1:0] strobe);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
         @(negedge clk);
         if (k == S) begin
            rd_ready = strobe[0];
            err_clr  = strobe[1];
         end else begin
            rd_ready = 1'b0;
            err_clr  = 1'b0;
         end
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                             input logic [1:0] strobe);
      logic par;
      bit   ok;
      par = ~(^b) ^ par_bad;
      send_bit(1'b0, 2'b00);
      for (int i = 0; i < 8; i++) send_bit(b[i], 2'b00);
      send_bit(par, 2'b00);
      send_bit(~stop_bad, strobe);
      repeat (HALF) @(negedge clk);
      // Model: the pop and the clear happen on the same edge as the frame result.
      ok = !par_bad && !stop_bad;
      if (strobe[0] && m_q.size() != 0) void'(m_q.pop_front());
      if (strobe[1]) begin m_par = 0; m_frm = 0; m_ovf = 0; end
      if (ok) begin
         m_last = {m_last[7:0], b};
         // A pop has already freed its slot, so a concurrent pop makes room.
         if (m_q.size() < D) m_q.push_back(b);
         else m_ovf = 1'b1;
      end
      if (par_bad) m_par = 1'b1;
      if (stop_bad) m_frm = 1'b1;
      $display("frame %02h pb=%0d sb=%0d strobe=%b -> count=%0d last=%04h flags=%b%b%b",
               b, par_bad, stop_bad, strobe, count, last_code, err_parity, err_frame, err_overflow);
      check_all($sformatf("frame_%02h", b));
   endtask

   task automatic send_partial(input int nbits);
      send_bit(1'b0, 2'b00);
      for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), 2'b00);
   endtask

   task automatic pop_one();
      @(negedge clk) rd_ready = 1'b1;
      @(negedge clk) rd_ready = 1'b0;
      if (m_q.size() != 0) void'(m_q.pop_front());
      $display("pop -> count=%0d rd_valid=%0d rd_data=%02h", count, rd_valid, rd_data);
      check_all("pop");
   endtask

   task automatic clear_errs();
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      m_par = 0; m_frm = 0; m_ovf = 0;
      $display("err_clr -> flags=%b%b%b", err_parity, err_frame, err_overflow);
      check_all("clr");
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, ".valid"}, 32'(rd_valid), 0);
      check_val({tag, ".data"}, 32'(rd_data), 0);
      check_val({tag, ".count"}, 32'(count), 0);
      check_val({tag, ".last"}, 32'(last_code), 0);
      check_val({tag, ".flags"}, 32'({err_parity, err_frame, err_overflow}), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_all("post_reset");

      // 1: good frame 0x1C
      send_frame(8'h1C, 0, 0, 2'b00);
      pop_one();

      // 2: parity error, then clear
      send_frame(8'h1C, 1, 0, 2'b00);
      clear_errs();

      // 3: stalled frame hits the watchdog, then a good frame
      send_partial(5);
      repeat (TO + 50) @(negedge clk);
      m_frm = 1'b1;
      $display("timeout -> err_frame=%0d", err_frame);
      check_all("timeout");
      send_frame(8'h32, 0, 0, 2'b00);
      pop_one();
      clear_errs();

      // 4: overflow with rd_ready low; the empty FIFO ignores rd_ready
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 2'b00);
      repeat (5) pop_one();
      clear_errs();

      // 5: history word, then a pop concurrent with a push at full
      send_frame(8'hE0, 0, 0, 2'b00);
      send_frame(8'h75, 0, 0, 2'b00);
      send_frame(8'h11, 0, 0, 2'b00);
      send_frame(8'h22, 0, 0, 2'b00);
      send_frame(8'h33, 0, 0, 2'b01);
      // A set wins over a clear on the same edge.
      send_frame(8'h44, 1, 1, 2'b10);
      repeat (4) pop_one();
      clear_errs();

      // 6: reset mid-frame, then a clean frame
      send_frame(8'h5A, 0, 0, 2'b00);
      send_partial(4);
      #2 rst_n = 1'b0;
      #1 check_zero("midreset");
      m_q.delete(); m_last = 0; m_par = 0; m_frm = 0; m_ovf = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send_frame(8'hAA, 0, 0, 2'b00);
      pop_one();

      // Randomised traffic
      for (int n = 0; n < 30; n++) begin
         int r;
         r = $urandom_range(0, 9);
         send_frame(8'($urandom_range(0, 255)), (r == 0) || (r == 2), (r == 1) || (r == 2),
                    2'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 2)) pop_one();
         if ($urandom_range(0, 4) == 0) clear_errs();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
